// File: rtl/fsqm_pkg.sv
// Shared types and width helpers for the float_sq_mul_p unit.
// Widths are derived from EXP_W / MAN_W through constant functions so that
// every instantiation size gets consistent bias, product and exponent widths.
package fsqm_pkg;

  // Controller states: two multiply/normalise/round passes, then pack.
  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL1,
    S_NORM1,
    S_RND1,
    S_MUL2,
    S_NORM2,
    S_RND2,
    S_PACK
  } fsqm_state_e;

  // Default field widths (IEEE single precision).
  localparam int FSQM_EXP_W_DEF = 8;
  localparam int FSQM_MAN_W_DEF = 23;

  // Exponent bias: 2^(EXP_W-1)-1.
  function automatic int fsqm_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Width of the full significand product (hidden bits included).
  function automatic int fsqm_prod_w(input int man_w);
    return 2 * (man_w + 1);
  endfunction

  // Width of the signed, unbiased working exponent.
  function automatic int fsqm_sexp_w(input int exp_w);
    return exp_w + 2;
  endfunction

  // Canonical quiet NaN, right-aligned: sign 0, exponent all-ones, mantissa MSB set.
  function automatic logic [63:0] fsqm_qnan(input int exp_w, input int man_w);
    logic [63:0] r;
    r = '0;
    r[man_w - 1] = 1'b1;
    for (int i = 0; i < exp_w; i++) begin
      r[man_w + i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fsqm_norm_round.sv
// Combinational normalise + round-to-nearest-even for one significand product.
// The normalise half shifts a product in [2,4) down by one and folds the
// dropped LSB into a sticky bit; the round half keeps MAN_W+1 significant bits
// using guard/round/sticky. Feeding an already-normalised product makes the
// normalise half a pass-through, which lets one instance serve both the NORM
// and RND states of each pass.
module fsqm_norm_round
  import fsqm_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int PW = fsqm_prod_w(MAN_W),
  localparam int SW = fsqm_sexp_w(EXP_W)
) (
  input  logic [PW-1:0]        prod,
  input  logic signed [SW-1:0] exp_in,
  input  logic                 sticky_in,
  output logic [PW-1:0]        norm_prod,
  output logic signed [SW-1:0] norm_exp,
  output logic                 norm_sticky,
  output logic [MAN_W:0]       rnd_man,
  output logic signed [SW-1:0] rnd_exp
);

  logic [MAN_W:0]   kept;
  logic             guard_bit;
  logic             round_bit;
  logic             sticky_bit;
  logic             round_up;
  logic [MAN_W+1:0] sum;

  // Normalise: a set product MSB means the value is >= 2.
  always_comb begin
    norm_prod   = prod;
    norm_exp    = exp_in;
    norm_sticky = sticky_in;
    if (prod[PW-1]) begin
      norm_prod   = prod >> 1;
      norm_exp    = exp_in + SW'(1);
      norm_sticky = sticky_in | prod[0];
    end
  end

  // Round to nearest, ties to even; a carry-out renormalises to 1.0 and bumps the exponent.
  always_comb begin
    kept       = norm_prod[PW-2 -: MAN_W+1];
    guard_bit  = norm_prod[MAN_W-1];
    round_bit  = norm_prod[MAN_W-2];
    sticky_bit = (|norm_prod[MAN_W-3:0]) | norm_sticky;
    round_up   = guard_bit & (round_bit | sticky_bit | kept[0]);
    sum        = {1'b0, kept} + {{(MAN_W+1){1'b0}}, round_up};
    rnd_man    = sum[MAN_W:0];
    rnd_exp    = norm_exp;
    if (sum[MAN_W+1]) begin
      rnd_man = sum[MAN_W+1:1];
      rnd_exp = norm_exp + SW'(1);
    end
  end

endmodule

// File: rtl/float_sq_mul_p.sv
// float_sq_mul_p: multi-cycle a^2*b (mode=1) or a*b (mode=0) floating-point unit
// with round-to-nearest-even after each multiply pass, overflow/underflow flags
// and a busy/ready handshake. Fixed latency: 7 edges (square), 4 edges (multiply).
// Optional feature macro: FSQM_SPECIALS_EN -- when defined, NaN and infinity
// inputs produce IEEE results; otherwise an all-ones exponent is an ordinary value.
module float_sq_mul_p
  import fsqm_pkg::*;
#(
  parameter int EXP_W = FSQM_EXP_W_DEF,
  parameter int MAN_W = FSQM_MAN_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   mode,
  input  logic [EXP_W+MAN_W:0]   op_a,
  input  logic [EXP_W+MAN_W:0]   op_b,
  output logic [EXP_W+MAN_W:0]   float_out,
  output logic                   ready,
  output logic                   busy,
  output logic                   ovf,
  output logic                   unf
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int PW   = fsqm_prod_w(MAN_W);
  localparam int SW   = fsqm_sexp_w(EXP_W);
  localparam int BIAS = fsqm_bias(EXP_W);

  // Per-operand field decode; index 0 is a, index 1 is b.
  logic [1:0][W-1:0]     ops;
  logic [1:0]            in_sign;
  logic [1:0]            in_zero;
  logic [1:0][EXP_W-1:0] in_expf;
  logic [1:0][MAN_W-1:0] in_frac;
  logic signed [SW-1:0]  in_exp [2];

  assign ops = {op_b, op_a};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_op
      assign in_sign[gi] = ops[gi][W-1];
      assign in_expf[gi] = ops[gi][W-2 -: EXP_W];
      assign in_frac[gi] = ops[gi][MAN_W-1:0];
      assign in_zero[gi] = (in_expf[gi] == '0);
      assign in_exp[gi]  = {2'b00, in_expf[gi]} - SW'(BIAS);
    end
  endgenerate

`ifdef FSQM_SPECIALS_EN
  localparam logic [63:0] QNAN_FULL = fsqm_qnan(EXP_W, MAN_W);
  logic [1:0] in_ones;
  logic [1:0] in_frac_nz;
  logic       nan_reg;
  logic       inf_reg;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_spec
      assign in_ones[gi]    = &in_expf[gi];
      assign in_frac_nz[gi] = |in_frac[gi];
    end
  endgenerate
`endif

  fsqm_state_e          state_reg;
  logic                 sign_reg;
  logic                 zero_reg;
  logic [MAN_W:0]       m1_reg;
  logic signed [SW-1:0] e1_reg;
  logic [MAN_W:0]       mb_reg;
  logic signed [SW-1:0] eb_reg;
  logic [PW-1:0]        prod_reg;
  logic signed [SW-1:0] exp_reg;
  logic                 lost_reg;
  logic [W-1:0]         out_reg;
  logic                 ready_reg;
  logic                 busy_reg;
  logic                 ovf_reg;
  logic                 unf_reg;

  logic [PW-1:0]        norm_prod;
  logic signed [SW-1:0] norm_exp;
  logic                 norm_sticky;
  logic [MAN_W:0]       rnd_man;
  logic signed [SW-1:0] rnd_exp;

  logic [SW-1:0]        biased;
  logic                 exp_hi;
  logic                 exp_lo;
  logic [W-1:0]         res;
  logic                 res_ovf;
  logic                 res_unf;

  fsqm_norm_round #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_norm_round (
    .prod        (prod_reg),
    .exp_in      (exp_reg),
    .sticky_in   (lost_reg),
    .norm_prod   (norm_prod),
    .norm_exp    (norm_exp),
    .norm_sticky (norm_sticky),
    .rnd_man     (rnd_man),
    .rnd_exp     (rnd_exp)
  );

  // Final result selection from the rounded second-pass value and the captured operand class.
  always_comb begin
    biased  = e1_reg + SW'(BIAS);
    exp_hi  = !biased[SW-1] && (biased[SW-2:0] >= {1'b0, {EXP_W{1'b1}}});
    exp_lo  = biased[SW-1] || (biased == '0);
    res     = {sign_reg, biased[EXP_W-1:0], m1_reg[MAN_W-1:0]};
    res_ovf = 1'b0;
    res_unf = 1'b0;
    if (zero_reg) begin
      res = {sign_reg, {(EXP_W+MAN_W){1'b0}}};
    end else if (exp_hi) begin
      res     = {sign_reg, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      res_ovf = 1'b1;
    end else if (exp_lo) begin
      res     = {sign_reg, {(EXP_W+MAN_W){1'b0}}};
      res_unf = 1'b1;
    end
`ifdef FSQM_SPECIALS_EN
    if (nan_reg) begin
      res     = QNAN_FULL[W-1:0];
      res_ovf = 1'b0;
      res_unf = 1'b0;
    end else if (inf_reg) begin
      res     = {sign_reg, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      res_ovf = 1'b0;
      res_unf = 1'b0;
    end
`endif
  end

  // Controller and datapath: capture, two multiply/normalise/round passes, pack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      sign_reg  <= 1'b0;
      zero_reg  <= 1'b0;
      m1_reg    <= '0;
      e1_reg    <= '0;
      mb_reg    <= '0;
      eb_reg    <= '0;
      prod_reg  <= '0;
      exp_reg   <= '0;
      lost_reg  <= 1'b0;
      out_reg   <= '0;
      ready_reg <= 1'b0;
      busy_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      unf_reg   <= 1'b0;
`ifdef FSQM_SPECIALS_EN
      nan_reg   <= 1'b0;
      inf_reg   <= 1'b0;
`endif
    end else begin
      ready_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            // a sits in the first-stage slot so multiply mode can skip pass one
            sign_reg  <= mode ? in_sign[1] : (in_sign[0] ^ in_sign[1]);
            zero_reg  <= |in_zero;
            m1_reg    <= {1'b1, in_frac[0]};
            e1_reg    <= in_exp[0];
            mb_reg    <= {1'b1, in_frac[1]};
            eb_reg    <= in_exp[1];
            busy_reg  <= 1'b1;
`ifdef FSQM_SPECIALS_EN
            nan_reg   <= (|(in_ones & in_frac_nz)) |
                         ((|(in_ones & ~in_frac_nz)) & (|in_zero));
            inf_reg   <= |(in_ones & ~in_frac_nz);
`endif
            state_reg <= mode ? S_MUL1 : S_MUL2;
          end
        end
        S_MUL1: begin
          prod_reg  <= PW'(m1_reg) * PW'(m1_reg);
          exp_reg   <= e1_reg + e1_reg;
          lost_reg  <= 1'b0;
          state_reg <= S_NORM1;
        end
        S_NORM1: begin
          prod_reg  <= norm_prod;
          exp_reg   <= norm_exp;
          lost_reg  <= norm_sticky;
          state_reg <= S_RND1;
        end
        S_RND1: begin
          m1_reg    <= rnd_man;
          e1_reg    <= rnd_exp;
          state_reg <= S_MUL2;
        end
        S_MUL2: begin
          prod_reg  <= PW'(m1_reg) * PW'(mb_reg);
          exp_reg   <= e1_reg + eb_reg;
          lost_reg  <= 1'b0;
          state_reg <= S_NORM2;
        end
        S_NORM2: begin
          prod_reg  <= norm_prod;
          exp_reg   <= norm_exp;
          lost_reg  <= norm_sticky;
          state_reg <= S_RND2;
        end
        S_RND2: begin
          m1_reg    <= rnd_man;
          e1_reg    <= rnd_exp;
          state_reg <= S_PACK;
        end
        S_PACK: begin
          out_reg   <= res;
          ovf_reg   <= res_ovf;
          unf_reg   <= res_unf;
          ready_reg <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign float_out = out_reg;
  assign ready     = ready_reg;
  assign busy      = busy_reg;
  assign ovf       = ovf_reg;
  assign unf       = unf_reg;

endmodule
